// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and helpers for the memory stage of the five-stage RISC-V
// pipeline: FSM state encoding, access-size encodings and byte-mask helpers.
// -----------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_e;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam logic [1:0] MEM_D = 2'd3;

  localparam int XLEN_BYTES = 8;

  // Byte-enable mask of an access of the given size, anchored at lane 0.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      MEM_B:   m = 8'h01;
      MEM_H:   m = 8'h03;
      MEM_W:   m = 8'h0F;
      MEM_D:   m = 8'hFF;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_lsb(input logic [1:0] size);
    logic [2:0] m;
    case (size)
      MEM_B:   m = 3'b000;
      MEM_H:   m = 3'b001;
      MEM_W:   m = 3'b011;
      MEM_D:   m = 3'b111;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

  // Number of bytes touched by an access of the given size.
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    logic [3:0] n;
    case (size)
      MEM_B:   n = 4'd1;
      MEM_H:   n = 4'd2;
      MEM_W:   n = 4'd4;
      MEM_D:   n = 4'd8;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Combinational byte-lane steering between a doubleword memory bus and the
// core. Stores: shift data and strobes up to the byte offset. Loads: shift the
// read doubleword down, truncate to the access size and sign/zero-extend.
// Ports:
//   i_off        byte offset inside the doubleword (already alignment-forced)
//   i_size       access size (MEM_B/H/W/D)
//   i_unsigned   zero-extend loads when 1
//   i_store_data store data from rs2
//   i_load_data  doubleword returned by memory
//   o_wdata      lane-shifted store data
//   o_wstrb      byte strobes
//   o_load_val   extracted, extended load value
// -----------------------------------------------------------------------------
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      i_off,
  input  logic [1:0]      i_size,
  input  logic            i_unsigned,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [XLEN-1:0] i_load_data,
  output logic [XLEN-1:0] o_wdata,
  output logic [7:0]      o_wstrb,
  output logic [XLEN-1:0] o_load_val
);

  logic [5:0]      w_shamt;
  logic [XLEN-1:0] w_shifted;

  // Lane steering for both directions plus load extension.
  always_comb begin
    w_shamt   = {i_off, 3'b000};
    o_wdata   = i_store_data << w_shamt;
    o_wstrb   = size_mask(i_size) << i_off;
    w_shifted = i_load_data >> w_shamt;
    case (i_size)
      MEM_B: begin
        if (i_unsigned) begin
          o_load_val = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
        end else begin
          o_load_val = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
        end
      end
      MEM_H: begin
        if (i_unsigned) begin
          o_load_val = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
        end else begin
          o_load_val = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
        end
      end
      MEM_W: begin
        if (i_unsigned) begin
          o_load_val = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
        end else begin
          o_load_val = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
        end
      end
      MEM_D:   o_load_val = w_shifted;
      default: o_load_val = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Memory stage of the five-stage RISC-V pipeline (between EX and WB).
// Non-memory ops pass straight to MEM/WB with one cycle of latency. Loads and
// stores go out over a valid/ready data-memory port; the stage stalls EX until
// the response (or write acknowledge) arrives, then registers the result.
// Ports:
//   clk, reset (async, active low)
//   EXMEM_*  / exmm_aluresult / dest_reg / mem_active / load : EX/MEM slot
//   MEMEX_stall, MEMEX_rd, MEMEX_rdval : stall and forwarding back to EX
//   dmem_req_* / dmem_resp_*           : data-memory port
//   MEMWB_*                            : registered MEM/WB slot
//   mem_misalign (only with MEM_MISALIGN_TRAP_EN) : misaligned-access pulse
// Build option MEM_MISALIGN_TRAP_EN: when defined, accesses that cross a
// doubleword are dropped without a request and flagged on mem_misalign; when
// undefined, the low address bits are forced to natural alignment.
// -----------------------------------------------------------------------------
module mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int REGW = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            EXMEM_ready,
  input  logic [XLEN-1:0] exmm_aluresult,
  input  logic [XLEN-1:0] EXMEM_rs2,
  input  logic [REGW-1:0] dest_reg,
  input  logic            mem_active,
  input  logic            load,
  input  logic            EXMEM_wbactive,
  input  logic [1:0]      EXMEM_size,
  input  logic            EXMEM_unsigned,
  output logic            MEMEX_stall,
  output logic [REGW-1:0] MEMEX_rd,
  output logic [XLEN-1:0] MEMEX_rdval,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_req_addr,
  output logic            dmem_req_we,
  output logic [XLEN-1:0] dmem_req_wdata,
  output logic [7:0]      dmem_req_wstrb,
  input  logic            dmem_resp_valid,
  input  logic [XLEN-1:0] dmem_resp_data,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic            mem_misalign,
`endif
  output logic            MEMWB_ready,
  output logic [REGW-1:0] MEMWB_rd,
  output logic [XLEN-1:0] MEMWB_rdval,
  output logic            MEMWB_wbactive
);

  mem_state_e r_state, w_state_nxt;

  // Copy of the accepted memory op so request fields stay stable in REQ/WAIT.
  logic [XLEN-1:0] r_addr, r_rs2;
  logic [REGW-1:0] r_rd;
  logic [1:0]      r_size;
  logic            r_load, r_wbactive, r_unsigned;

  logic            r_wb_ready, r_wb_wbactive;
  logic [REGW-1:0] r_wb_rd;
  logic [XLEN-1:0] r_wb_rdval;

  logic [XLEN-1:0] w_cur_addr, w_cur_rs2;
  logic [1:0]      w_cur_size;
  logic            w_cur_load, w_cur_unsigned;
  logic [2:0]      w_off;
  logic            w_trap;
  logic            w_latch, w_stall, w_req_valid, w_store_req;
  logic            w_wb_ready_nxt, w_wb_wbactive_nxt;
  logic [REGW-1:0] w_wb_rd_nxt;
  logic [XLEN-1:0] w_wb_rdval_nxt;
  logic [XLEN-1:0] w_wdata, w_load_val;
  logic [7:0]      w_wstrb;

  // In IDLE the live EX/MEM inputs drive the request; afterwards the copy does.
  assign w_cur_addr     = (r_state == IDLE) ? exmm_aluresult : r_addr;
  assign w_cur_rs2      = (r_state == IDLE) ? EXMEM_rs2      : r_rs2;
  assign w_cur_size     = (r_state == IDLE) ? EXMEM_size     : r_size;
  assign w_cur_load     = (r_state == IDLE) ? load           : r_load;
  assign w_cur_unsigned = (r_state == IDLE) ? EXMEM_unsigned : r_unsigned;

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_misalign, w_misalign_nxt;
  assign w_off  = w_cur_addr[2:0];
  // Crossing test: last byte of the access lands past the doubleword.
  assign w_trap = (({1'b0, w_off} + size_bytes(w_cur_size)) > 4'(XLEN_BYTES));
  assign mem_misalign = r_misalign;
`else
  assign w_off  = w_cur_addr[2:0] & ~align_lsb(w_cur_size);
  assign w_trap = 1'b0;
`endif

  mem_lane_align #(.XLEN(XLEN)) u_lane (
    .i_off        (w_off),
    .i_size       (w_cur_size),
    .i_unsigned   (w_cur_unsigned),
    .i_store_data (w_cur_rs2),
    .i_load_data  (dmem_resp_data),
    .o_wdata      (w_wdata),
    .o_wstrb      (w_wstrb),
    .o_load_val   (w_load_val)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, handshake outputs and next MEM/WB contents.
  always_comb begin
    w_state_nxt       = r_state;
    w_stall           = 1'b0;
    w_req_valid       = 1'b0;
    w_latch           = 1'b0;
    w_wb_ready_nxt    = 1'b0;
    w_wb_wbactive_nxt = 1'b0;
    w_wb_rd_nxt       = r_wb_rd;
    w_wb_rdval_nxt    = r_wb_rdval;
`ifdef MEM_MISALIGN_TRAP_EN
    w_misalign_nxt    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (EXMEM_ready) begin
          if (mem_active) begin
            if (w_trap) begin
              // Dropped access: retire as a non-writing op, no request.
              w_wb_ready_nxt = 1'b1;
              w_wb_rd_nxt    = dest_reg;
              w_wb_rdval_nxt = {XLEN{1'b0}};
`ifdef MEM_MISALIGN_TRAP_EN
              w_misalign_nxt = 1'b1;
`endif
            end else begin
              w_stall     = 1'b1;
              w_req_valid = 1'b1;
              w_latch     = 1'b1;
              if (dmem_req_ready) begin
                w_state_nxt = WAIT;
              end else begin
                w_state_nxt = REQ;
              end
            end
          end else begin
            w_wb_ready_nxt    = 1'b1;
            w_wb_rd_nxt       = dest_reg;
            w_wb_rdval_nxt    = exmm_aluresult;
            w_wb_wbactive_nxt = EXMEM_wbactive;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      REQ: begin
        w_stall     = 1'b1;
        w_req_valid = 1'b1;
        if (dmem_req_ready) begin
          w_state_nxt = WAIT;
        end else begin
          w_state_nxt = REQ;
        end
      end
      WAIT: begin
        if (dmem_resp_valid) begin
          // Release EX on the same edge the result lands in MEM/WB.
          w_state_nxt    = IDLE;
          w_wb_ready_nxt = 1'b1;
          w_wb_rd_nxt    = r_rd;
          if (r_load) begin
            w_wb_rdval_nxt    = w_load_val;
            w_wb_wbactive_nxt = r_wbactive;
          end else begin
            w_wb_rdval_nxt    = {XLEN{1'b0}};
            w_wb_wbactive_nxt = 1'b0;
          end
        end else begin
          w_stall = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Capture the memory op when it is accepted out of IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr     <= {XLEN{1'b0}};
      r_rs2      <= {XLEN{1'b0}};
      r_rd       <= {REGW{1'b0}};
      r_size     <= 2'd0;
      r_load     <= 1'b0;
      r_wbactive <= 1'b0;
      r_unsigned <= 1'b0;
    end else if (w_latch) begin
      r_addr     <= exmm_aluresult;
      r_rs2      <= EXMEM_rs2;
      r_rd       <= dest_reg;
      r_size     <= EXMEM_size;
      r_load     <= load;
      r_wbactive <= EXMEM_wbactive;
      r_unsigned <= EXMEM_unsigned;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wb_ready    <= 1'b0;
      r_wb_wbactive <= 1'b0;
      r_wb_rd       <= {REGW{1'b0}};
      r_wb_rdval    <= {XLEN{1'b0}};
    end else begin
      r_wb_ready    <= w_wb_ready_nxt;
      r_wb_wbactive <= w_wb_wbactive_nxt;
      r_wb_rd       <= w_wb_rd_nxt;
      r_wb_rdval    <= w_wb_rdval_nxt;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Misalignment flag, aligned with the MEM/WB slot it belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_misalign_nxt;
    end
  end
`endif

  // Write fields are zeroed for loads and when no request is presented.
  assign w_store_req    = w_req_valid & ~w_cur_load;
  assign MEMEX_stall    = w_stall;
  assign dmem_req_valid = w_req_valid;
  assign dmem_req_addr  = w_req_valid ? {w_cur_addr[XLEN-1:3], 3'b000} : {XLEN{1'b0}};
  assign dmem_req_we    = w_store_req;
  assign dmem_req_wdata = w_store_req ? w_wdata : {XLEN{1'b0}};
  assign dmem_req_wstrb = w_store_req ? w_wstrb : 8'h00;

  assign MEMWB_ready    = r_wb_ready;
  assign MEMWB_rd       = r_wb_rd;
  assign MEMWB_rdval    = r_wb_rdval;
  assign MEMWB_wbactive = r_wb_wbactive;

  // Forward only a live, writing, non-x0 result.
  assign MEMEX_rd    = (r_wb_ready && r_wb_wbactive && (r_wb_rd != {REGW{1'b0}}))
                       ? r_wb_rd : {REGW{1'b0}};
  assign MEMEX_rdval = r_wb_rdval;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Directed self-checking bench for mem_stage with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 time
// unit later (combinational) or 1 time unit after the next rising edge.
// -----------------------------------------------------------------------------
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        EXMEM_ready, mem_active, load, EXMEM_wbactive, EXMEM_unsigned;
  logic [63:0] exmm_aluresult, EXMEM_rs2;
  logic [5:0]  dest_reg;
  logic [1:0]  EXMEM_size;
  logic        MEMEX_stall;
  logic [5:0]  MEMEX_rd;
  logic [63:0] MEMEX_rdval;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we, dmem_resp_valid;
  logic [63:0] dmem_req_addr, dmem_req_wdata, dmem_resp_data;
  logic [7:0]  dmem_req_wstrb;
  logic        MEMWB_ready, MEMWB_wbactive;
  logic [5:0]  MEMWB_rd;
  logic [63:0] MEMWB_rdval;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        mem_misalign;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int pulses;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(64), .REGW(6)) dut (
    .clk             (clk),
    .reset           (reset),
    .EXMEM_ready     (EXMEM_ready),
    .exmm_aluresult  (exmm_aluresult),
    .EXMEM_rs2       (EXMEM_rs2),
    .dest_reg        (dest_reg),
    .mem_active      (mem_active),
    .load            (load),
    .EXMEM_wbactive  (EXMEM_wbactive),
    .EXMEM_size      (EXMEM_size),
    .EXMEM_unsigned  (EXMEM_unsigned),
    .MEMEX_stall     (MEMEX_stall),
    .MEMEX_rd        (MEMEX_rd),
    .MEMEX_rdval     (MEMEX_rdval),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_req_addr   (dmem_req_addr),
    .dmem_req_we     (dmem_req_we),
    .dmem_req_wdata  (dmem_req_wdata),
    .dmem_req_wstrb  (dmem_req_wstrb),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_resp_data  (dmem_resp_data),
`ifdef MEM_MISALIGN_TRAP_EN
    .mem_misalign    (mem_misalign),
`endif
    .MEMWB_ready     (MEMWB_ready),
    .MEMWB_rd        (MEMWB_rd),
    .MEMWB_rdval     (MEMWB_rdval),
    .MEMWB_wbactive  (MEMWB_wbactive)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    EXMEM_ready = 1'b0; mem_active = 1'b0; load = 1'b0; EXMEM_wbactive = 1'b0;
    EXMEM_size = MEM_B; EXMEM_unsigned = 1'b0; exmm_aluresult = 64'h0;
    EXMEM_rs2 = 64'h0; dest_reg = 6'd0; dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b0; dmem_resp_data = 64'h0;
  endtask

  task automatic set_op(input logic [63:0] addr, input logic [63:0] rs2, input logic [5:0] rd,
                        input logic mem, input logic ld, input logic wb,
                        input logic [1:0] sz, input logic uns);
    EXMEM_ready = 1'b1; exmm_aluresult = addr; EXMEM_rs2 = rs2; dest_reg = rd;
    mem_active = mem; load = ld; EXMEM_wbactive = wb; EXMEM_size = sz; EXMEM_unsigned = uns;
  endtask

  // Zero-wait memory: accept in cycle 0, respond in cycle 1; returns after the result edge.
  task automatic mem_zero_wait(input string tag, input logic [63:0] resp, input logic [63:0] exp_addr);
    dmem_req_ready = 1'b1;
    #1;
    check_eq({tag, "_stall_c0"}, MEMEX_stall, 64'd1);
    check_eq({tag, "_reqv_c0"}, dmem_req_valid, 64'd1);
    check_eq({tag, "_addr"}, dmem_req_addr, exp_addr);
    tick;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b1; dmem_resp_data = resp;
    #1;
    check_eq({tag, "_stall_c1"}, MEMEX_stall, 64'd0);
    check_eq({tag, "_reqv_c1"}, dmem_req_valid, 64'd0);
    check_eq({tag, "_wbrdy_c1"}, MEMWB_ready, 64'd0);
    tick;
    dmem_resp_valid = 1'b0;
    EXMEM_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    tick; tick;
    check_eq("rst_wbready", MEMWB_ready, 64'd0);
    check_eq("rst_wbrd", MEMWB_rd, 64'd0);
    check_eq("rst_wbrdval", MEMWB_rdval, 64'd0);
    check_eq("rst_fwd_rd", MEMEX_rd, 64'd0);
    check_eq("rst_stall", MEMEX_stall, 64'd0);
    check_eq("rst_reqv", dmem_req_valid, 64'd0);
    reset = 1'b1;
    tick;

    // Non-memory op: one-cycle pass-through, forwarded.
    set_op(64'h1234, 64'h0, 6'd5, 1'b0, 1'b0, 1'b1, MEM_D, 1'b0);
    #1;
    check_eq("alu_stall", MEMEX_stall, 64'd0);
    check_eq("alu_reqv", dmem_req_valid, 64'd0);
    tick;
    idle_inputs();
    check_eq("alu_wbready", MEMWB_ready, 64'd1);
    check_eq("alu_wbrd", MEMWB_rd, 64'd5);
    check_eq("alu_wbrdval", MEMWB_rdval, 64'h1234);
    check_eq("alu_wbact", MEMWB_wbactive, 64'd1);
    check_eq("alu_fwd_rd", MEMEX_rd, 64'd5);
    check_eq("alu_fwd_val", MEMEX_rdval, 64'h1234);
    tick;
    check_eq("bubble_wbready", MEMWB_ready, 64'd0);
    check_eq("bubble_wbact", MEMWB_wbactive, 64'd0);
    check_eq("bubble_fwd_rd", MEMEX_rd, 64'd0);

    // lb at 0x1003, byte 3 = 0x80 -> sign-extended.
    set_op(64'h1003, 64'h0, 6'd7, 1'b1, 1'b1, 1'b1, MEM_B, 1'b0);
    mem_zero_wait("lb", 64'h0000_0000_8000_0000, 64'h1000);
    check_eq("lb_wbready", MEMWB_ready, 64'd1);
    check_eq("lb_val", MEMWB_rdval, 64'hFFFF_FFFF_FFFF_FF80);
    check_eq("lb_fwd_rd", MEMEX_rd, 64'd7);

    // lbu on the same byte -> zero-extended.
    set_op(64'h1003, 64'h0, 6'd8, 1'b1, 1'b1, 1'b1, MEM_B, 1'b1);
    mem_zero_wait("lbu", 64'h0000_0000_8000_0000, 64'h1000);
    check_eq("lbu_val", MEMWB_rdval, 64'h80);
    check_eq("lbu_wbrd", MEMWB_rd, 64'd8);

    // sh 0xBEEF at 0x2006 -> top two lanes.
    set_op(64'h2006, 64'hBEEF, 6'd9, 1'b1, 1'b0, 1'b1, MEM_H, 1'b0);
    #1;
    check_eq("sh_we", dmem_req_we, 64'd1);
    check_eq("sh_wstrb", dmem_req_wstrb, 64'hC0);
    check_eq("sh_wdata", dmem_req_wdata, 64'hBEEF_0000_0000_0000);
    mem_zero_wait("sh", 64'h0, 64'h2000);
    check_eq("sh_wbready", MEMWB_ready, 64'd1);
    check_eq("sh_wbact", MEMWB_wbactive, 64'd0);
    check_eq("sh_fwd_rd", MEMEX_rd, 64'd0);

    // lw at 0x3004 with 3 not-ready cycles then a 2-cycle response.
    set_op(64'h3004, 64'h0, 6'd11, 1'b1, 1'b1, 1'b1, MEM_W, 1'b0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      dmem_req_ready  = (c == 3);
      dmem_resp_valid = (c == 5);
      dmem_resp_data  = 64'h89AB_CDEF_0000_0000;
      #1;
      check_eq($sformatf("slow_stall_c%0d", c), MEMEX_stall, (c == 5) ? 64'd0 : 64'd1);
      check_eq($sformatf("slow_reqv_c%0d", c), dmem_req_valid, (c <= 3) ? 64'd1 : 64'd0);
      check_eq($sformatf("slow_addr_c%0d", c), dmem_req_addr, (c <= 3) ? 64'h3000 : 64'h0);
      check_eq($sformatf("slow_we_c%0d", c), dmem_req_we, 64'd0);
      tick;
      pulses += int'(MEMWB_ready);
      if (c == 0) begin
        // EX-side inputs wander; the request must not follow them.
        exmm_aluresult = 64'hFFF0; EXMEM_size = MEM_D; load = 1'b0;
      end
    end
    check_eq("slow_val", MEMWB_rdval, 64'hFFFF_FFFF_89AB_CDEF);
    check_eq("slow_wbrd", MEMWB_rd, 64'd11);
    idle_inputs();
    tick;
    pulses += int'(MEMWB_ready);
    check_eq("slow_pulses", pulses, 64'd1);

    // Reset while waiting; a late response must be discarded.
    set_op(64'h40, 64'h0, 6'd3, 1'b1, 1'b1, 1'b1, MEM_D, 1'b0);
    dmem_req_ready = 1'b1;
    tick;
    dmem_req_ready = 1'b0;
    EXMEM_ready = 1'b0;
    reset = 1'b0;
    #1;
    check_eq("rstw_stall", MEMEX_stall, 64'd0);
    check_eq("rstw_reqv", dmem_req_valid, 64'd0);
    check_eq("rstw_wbrd", MEMWB_rd, 64'd0);
    check_eq("rstw_wbrdval", MEMWB_rdval, 64'd0);
    tick;
    reset = 1'b1;
    dmem_resp_valid = 1'b1; dmem_resp_data = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    check_eq("late_stall", MEMEX_stall, 64'd0);
    tick;
    dmem_resp_valid = 1'b0;
    check_eq("late_wbready", MEMWB_ready, 64'd0);
    check_eq("late_wbrdval", MEMWB_rdval, 64'd0);
    check_eq("late_fwd_rd", MEMEX_rd, 64'd0);

    // lw at 0x6 crosses a doubleword.
    set_op(64'h6, 64'h0, 6'd12, 1'b1, 1'b1, 1'b1, MEM_W, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
    dmem_req_ready = 1'b1;
    #1;
    check_eq("mis_reqv", dmem_req_valid, 64'd0);
    check_eq("mis_stall", MEMEX_stall, 64'd0);
    tick;
    idle_inputs();
    check_eq("mis_flag", mem_misalign, 64'd1);
    check_eq("mis_wbready", MEMWB_ready, 64'd1);
    check_eq("mis_wbact", MEMWB_wbactive, 64'd0);
    tick;
    check_eq("mis_flag_drop", mem_misalign, 64'd0);
`else
    mem_zero_wait("lw6", 64'h1122_3344_5566_7788, 64'h0);
    check_eq("lw6_val", MEMWB_rdval, 64'h1122_3344);
    check_eq("lw6_wbrd", MEMWB_rd, 64'd12);
`endif
    idle_inputs();
    tick;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
